// File: rtl/lab7_2_pkg.sv
// Shared constants for the tick counter: edge-selection codes and the default
// debounce depth.
package lab7_2_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  localparam int DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/lab7_2_tick_counter_if.sv
// Signal bundle between the software-facing PIO glue and the tick counter.
// The master drives the input and the strobes. The counter (slave) drives the
// count and status.
interface lab7_2_tick_counter_if #(
  parameter int WIDTH = 8
);

  logic             sig_in;
  logic             enable;
  logic             clear;
  logic [WIDTH-1:0] count_out;
  logic             overflow;
  logic             level;

  modport master (
    output sig_in, enable, clear,
    input  count_out, overflow, level
  );

  modport slave (
    input  sig_in, enable, clear,
    output count_out, overflow, level
  );

endinterface

// File: rtl/lab7_2_input_debouncer.sv
// Two-FF synchronizer followed by a stability filter. The level only changes
// after DEBOUNCE_CYCLES consecutive disagreeing samples (0 = pass-through).
module lab7_2_input_debouncer
  import lab7_2_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic level
);

  logic sync1, sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or posedge reset) begin
        if (reset) level <= 1'b0;
        else       level <= sync2;
      end
    end else begin : g_filter
      localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] db_cnt;

      // Any sample that agrees with the current level restarts the run,
      // so only an unbroken run of disagreement is accepted.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          level  <= 1'b0;
          db_cnt <= '0;
        end else if (sync2 == level) begin
          db_cnt <= '0;
        end else if (db_cnt == LAST) begin
          level  <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/lab7_2_tick_counter.sv
// Counts debounced edges of an asynchronous input into a register that feeds
// a PIO in_port directly. It has a synchronous clear and a sticky overflow flag.
module lab7_2_tick_counter
  import lab7_2_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int EDGE_MODE       = EDGE_RISE,
  parameter int SATURATE        = 0
) (
  input logic                  clk,
  input logic                  reset,
  lab7_2_tick_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic             level, level_d;
  logic             rise, fall, hit;
  logic [WIDTH-1:0] cnt;
  logic             ovf;

  lab7_2_input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk   (clk),
    .reset (reset),
    .sig_in(bus.sig_in),
    .level (level)
  );

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

  always_comb begin
    hit = rise;
    case (EDGE_MODE)
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = rise;
    endcase
  end

  // Clear wins over a same-cycle hit; a hit while disabled is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_d <= 1'b0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else begin
      level_d <= level;
      if (bus.clear) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (hit && bus.enable) begin
        if (cnt != ALL_ONES) begin
          cnt <= cnt + WIDTH'(1);
        end else begin
          ovf <= 1'b1;
          if (SATURATE == 0) cnt <= '0;
        end
      end
    end
  end

  assign bus.count_out = cnt;
  assign bus.overflow  = ovf;
  assign bus.level     = level;

endmodule

// File: doc/lab7_2_tick_counter.md
Name: lab7_2_tick_counter

Overview:
Upstream feeder for the 8-bit Avalon input PIO. It synchronizes an asynchronous external signal, debounces it, and detects qualifying edges. It counts those edges in a registered counter that drives the PIO in_port directly. Software reads the count through the PIO and resets it via a clear strobe from a separate output PIO.

Parameters:
WIDTH, 8, counter and count_out width; matches the PIO in_port width.
DEBOUNCE_CYCLES, 4, number of consecutive stable synchronized samples required to accept a level change; 0 = debounce bypassed.
EDGE_MODE, 0, which edges are counted: 0 = rising, 1 = falling, 2 = both.
SATURATE, 0, counter overflow policy: 0 = wrap modulo 2^WIDTH, 1 = hold at all-ones.

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
sig_in  input  1  external asynchronous signal to be counted
enable  input  1  synchronous count enable; 0 freezes the counter (sync/debounce keep running)
clear  input  1  synchronous clear strobe (level-sensitive, one or more cycles)
count_out  output  WIDTH  registered edge count; connects to PIO in_port
overflow  output  1  sticky flag, set on wrap or on a saturation attempt
level  output  1  debounced signal level, registered

Behaviour:
- Reset (async, reset=1): sync FFs, debounced level, delayed level, debounce counter, count_out, and overflow all go to 0. No edge is detected at reset release, even if sig_in is high; the sync chain starts from 0, so a high sig_in at release is counted as one rising edge once it propagates.
- Sync: two-FF chain, sync1 <= sig_in, sync2 <= sync1. No logic between the FFs.
- Debounce, DEBOUNCE_CYCLES = N >= 1:
  - db_cnt width is clog2(N)+1.
  - If sync2 == level: db_cnt <= 0.
  - Else if db_cnt == N-1: level <= sync2, db_cnt <= 0.
  - Else: db_cnt <= db_cnt + 1.
  - Any mismatch gap restarts the count, so pulses shorter than N synchronized cycles are rejected.
- Debounce, N = 0: level <= sync2 every cycle.
- Edge detect:
  - level_d <= level.
  - rise = level & ~level_d; fall = ~level & level_d.
  - hit = rise (mode 0), fall (mode 1), or rise | fall (mode 2).
- Counter priority per cycle:
  1. clear=1: count_out <= 0, overflow <= 0, and any simultaneous hit is discarded.
  2. Else if hit & enable and count_out != all-ones: count_out <= count_out + 1.
  3. Else if hit & enable and count_out == all-ones: overflow <= 1, and count_out <= 0 (SATURATE=0) or holds all-ones (SATURATE=1).
  4. Otherwise hold.
- Latency: with the first high sample of sig_in taken at clock edge 0, count_out updates at edge max(N,1)+2. For N=4 that is edge 6.
- A hit while enable=0 is lost, not deferred.
- Reset asserted mid-debounce or mid-count aborts immediately; all state returns to reset values.
- The counter is WIDTH bits with unsigned arithmetic; overflow is the only width-extension indicator.

Decomposition:
- Shared package lab7_2_pkg holds EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2, and the default DEBOUNCE_CYCLES.
- One sub-module, lab7_2_input_debouncer, contains the 2-FF sync and the debounce counter and outputs level. The edge detect and counter stay in the top.

Test Plan:
- Reset with sig_in=1 held, then release; N=4, mode 0 -> count_out=0 during reset, then count_out=1 exactly 6 edges after the first post-release sample; overflow=0.
- N=4, mode 0: glitch high for 3 cycles, then a 10-cycle pulse -> glitch is ignored; count_out goes 0->1 once; level follows with a 5-edge delay.
- Mode 2, N=0: five clean 8-cycle pulses -> count_out=10; each increment occurs 3 edges after the corresponding sig_in transition is sampled.
- SATURATE=0: preload to 255 via 255 pulses, then one more pulse -> count_out=0, overflow=1. Repeat with SATURATE=1 -> count_out=255, overflow=1.
- Drive clear in the same cycle that hit=1 with count_out=7 -> count_out=0, overflow=0, and the edge is not counted. Next pulse -> count_out=1.
- enable=0 during 3 pulses, then enable=1 for 2 pulses -> count_out=2. Assert reset mid-pulse -> all outputs are 0 asynchronously, before the next clk edge.
